memory_reader: RTL and testbench

MEMORY_READER -- requirements
Module: memory_reader

---
 rtl/memory_pkg.sv | 15 +
 rtl/memory_reader.sv | 105 ++++++++++
 tb/tb_memory_reader.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_pkg.sv
// Shared definitions for the 4x8 byte memory and its reader.
package memory_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 2;
    localparam int unsigned DEPTH  = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_CAPTURE,
        ST_PRESENT
    } reader_state_t;

endpackage

// File: rtl/memory_reader.sv
// Reads one byte, or scans all four locations, from a combinational byte memory
// and presents each captured byte on a valid/ready output.
module memory_reader
    import memory_pkg::*;
#(
    parameter int unsigned SETTLE = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              scan,
    input  logic [ADDR_W-1:0] start_addr,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE);

    reader_state_t     r_state;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_out_data;
    logic [ADDR_W-1:0] r_out_addr;
    logic              r_out_valid;
    logic              r_busy;
    logic              r_done;
    logic              r_scan;
    logic [1:0]        r_remaining;
    logic [3:0]        r_settle;
    logic              w_last;

    assign w_last = !r_scan || (r_remaining == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_mem_addr  <= '0;
            r_out_data  <= '0;
            r_out_addr  <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_scan      <= 1'b0;
            r_remaining <= '0;
            r_settle    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_mem_addr  <= start_addr;
                        r_scan      <= scan;
                        r_remaining <= scan ? 2'd3 : 2'd0;
                        r_settle    <= SETTLE_LD;
                        r_busy      <= 1'b1;
                        r_state     <= ST_WAIT;
                    end
                end
                // The counter is loaded with SETTLE, so leaving at 1 gives exactly SETTLE cycles here.
                ST_WAIT: begin
                    if (r_settle == 4'd1) begin
                        r_state <= ST_CAPTURE;
                    end else begin
                        r_settle <= r_settle - 4'd1;
                    end
                end
                ST_CAPTURE: begin
                    r_out_data  <= mem_data;
                    r_out_addr  <= r_mem_addr;
                    r_out_valid <= 1'b1;
                    r_state     <= ST_PRESENT;
                end
                ST_PRESENT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (w_last) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_mem_addr  <= r_mem_addr + ADDR_W'(1);
                            r_remaining <= r_remaining - 2'd1;
                            r_settle    <= SETTLE_LD;
                            r_state     <= ST_WAIT;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign mem_addr  = r_mem_addr;
    assign out_data  = r_out_data;
    assign out_addr  = r_out_addr;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_memory_reader.sv
// Scoreboard bench for memory_reader: instance A uses SETTLE=1, instance B uses SETTLE=4.
module tb_memory_reader;
    import memory_pkg::*;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] addr;
        logic              last;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic [DATA_W-1:0] rom [DEPTH];

    logic              start_a, scan_a, out_valid_a, out_ready_a, busy_a, done_a;
    logic [ADDR_W-1:0] start_addr_a, mem_addr_a, out_addr_a;
    logic [DATA_W-1:0] mem_data_a, out_data_a;
    logic              start_b, scan_b, out_valid_b, out_ready_b, busy_b, done_b;
    logic [ADDR_W-1:0] start_addr_b, mem_addr_b, out_addr_b;
    logic [DATA_W-1:0] mem_data_b, out_data_b;

    assign mem_data_a = rom[mem_addr_a];
    assign mem_data_b = rom[mem_addr_b];

    memory_reader #(.SETTLE(1)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .scan(scan_a), .start_addr(start_addr_a),
        .mem_addr(mem_addr_a), .mem_data(mem_data_a), .out_data(out_data_a), .out_addr(out_addr_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a), .busy(busy_a), .done(done_a)
    );

    memory_reader #(.SETTLE(4)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .scan(scan_b), .start_addr(start_addr_b),
        .mem_addr(mem_addr_b), .mem_data(mem_data_b), .out_data(out_data_b), .out_addr(out_addr_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .busy(busy_b), .done(done_b)
    );

    int n_checks = 0;
    int n_fail = 0;
    int n_done_a = 0;
    int n_done_b = 0;
    exp_t qa[$];
    exp_t qb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor A: pops the scoreboard on each handshake, checks done timing and hold stability.
    logic              pend_a = 1'b0;
    logic              hold_a = 1'b0;
    logic [DATA_W-1:0] hd_a;
    logic [ADDR_W-1:0] ha_a;
    exp_t              e_a;
    always @(negedge clk) begin
        if (reset) begin
            pend_a = 1'b0;
            hold_a = 1'b0;
        end else begin
            if (hold_a) begin
                check("a_hold_valid", 32'(out_valid_a), 32'd1);
                check("a_hold_data", 32'(out_data_a), 32'(hd_a));
                check("a_hold_addr", 32'(out_addr_a), 32'(ha_a));
            end
            if (pend_a || done_a) check("a_done", 32'(done_a), 32'(pend_a));
            if (done_a) n_done_a++;
            pend_a = 1'b0;
            if (out_valid_a && out_ready_a) begin
                if (qa.size() == 0) begin
                    check("a_unexpected_byte", 32'd1, 32'd0);
                end else begin
                    e_a = qa.pop_front();
                    check("a_data", 32'(out_data_a), 32'(e_a.data));
                    check("a_addr", 32'(out_addr_a), 32'(e_a.addr));
                    pend_a = e_a.last;
                end
            end
            hold_a = out_valid_a && !out_ready_a;
            hd_a = out_data_a;
            ha_a = out_addr_a;
        end
    end

    logic pend_b = 1'b0;
    exp_t e_b;
    always @(negedge clk) begin
        if (reset) begin
            pend_b = 1'b0;
        end else begin
            if (pend_b || done_b) check("b_done", 32'(done_b), 32'(pend_b));
            if (done_b) n_done_b++;
            pend_b = 1'b0;
            if (out_valid_b && out_ready_b) begin
                if (qb.size() == 0) begin
                    check("b_unexpected_byte", 32'd1, 32'd0);
                end else begin
                    e_b = qb.pop_front();
                    check("b_data", 32'(out_data_b), 32'(e_b.data));
                    check("b_addr", 32'(out_addr_b), 32'(e_b.addr));
                    pend_b = e_b.last;
                end
            end
        end
    end

    task automatic push_a(input logic [7:0] d, input logic [1:0] ad, input logic last);
        exp_t e;
        e.data = d;
        e.addr = ad;
        e.last = last;
        qa.push_back(e);
    endtask

    task automatic issue_a(input logic s, input logic [1:0] ad);
        @(posedge clk); #1;
        start_a = 1'b1;
        scan_a = s;
        start_addr_a = ad;
        @(posedge clk); #1;
        start_a = 1'b0;
    endtask

    task automatic latency_a(input int exp_lat);
        int lat = 1;
        while (!out_valid_a && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("a_latency", 32'(lat), 32'(exp_lat));
    endtask

    task automatic wait_idle_a(input string name);
        int n = 0;
        while (busy_a && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_idle"}, 32'(busy_a), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check({name, "_queue_empty"}, 32'(qa.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int d0;
        int n;
        int lat;
        exp_t e;
        rom[0] = 8'hA5; rom[1] = 8'h3C; rom[2] = 8'hFF; rom[3] = 8'h00;
        reset = 1'b1;
        start_a = 1'b0; scan_a = 1'b0; start_addr_a = '0; out_ready_a = 1'b0;
        start_b = 1'b0; scan_b = 1'b0; start_addr_b = '0; out_ready_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_addr", 32'(mem_addr_a), 32'd0);
        check("rst_out_data", 32'(out_data_a), 32'd0);
        check("rst_out_addr", 32'(out_addr_a), 32'd0);
        check("rst_out_valid", 32'(out_valid_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        reset = 1'b0;

        // Single read of location 2.
        out_ready_a = 1'b1;
        push_a(8'hFF, 2'd2, 1'b1);
        d0 = n_done_a;
        issue_a(1'b0, 2'd2);
        latency_a(3);
        wait_idle_a("single");
        check("single_done_count", 32'(n_done_a - d0), 32'd1);

        // Scan wrapping from location 3.
        push_a(8'h00, 2'd3, 1'b0);
        push_a(8'hA5, 2'd0, 1'b0);
        push_a(8'h3C, 2'd1, 1'b0);
        push_a(8'hFF, 2'd2, 1'b1);
        d0 = n_done_a;
        issue_a(1'b1, 2'd3);
        latency_a(3);
        wait_idle_a("wrap");
        check("wrap_done_count", 32'(n_done_a - d0), 32'd1);

        // Backpressure on the first byte of a scan from 0.
        out_ready_a = 1'b0;
        push_a(8'hA5, 2'd0, 1'b0);
        push_a(8'h3C, 2'd1, 1'b0);
        push_a(8'hFF, 2'd2, 1'b0);
        push_a(8'h00, 2'd3, 1'b1);
        d0 = n_done_a;
        issue_a(1'b1, 2'd0);
        latency_a(3);
        repeat (5) @(posedge clk);
        #1;
        check("bp_mem_addr", 32'(mem_addr_a), 32'd0);
        check("bp_out_data", 32'(out_data_a), 32'hA5);
        check("bp_out_valid", 32'(out_valid_a), 32'd1);
        out_ready_a = 1'b1;
        wait_idle_a("bp");
        check("bp_done_count", 32'(n_done_a - d0), 32'd1);

        // Start in the done cycle is accepted.
        push_a(8'hA5, 2'd0, 1'b1);
        push_a(8'h00, 2'd3, 1'b1);
        issue_a(1'b0, 2'd0);
        n = 0;
        while (!done_a && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("b2b_done_seen", 32'(done_a), 32'd1);
        start_a = 1'b1; scan_a = 1'b0; start_addr_a = 2'd3;
        @(posedge clk); #1;
        start_a = 1'b0;
        check("b2b_busy", 32'(busy_a), 32'd1);
        check("b2b_mem_addr", 32'(mem_addr_a), 32'd3);
        wait_idle_a("b2b");

        // Reset during the settle wait of the second scan byte.
        push_a(8'hA5, 2'd0, 1'b0);
        d0 = n_done_a;
        issue_a(1'b1, 2'd0);
        latency_a(3);
        @(posedge clk); #1;
        check("rmid_mem_addr_pre", 32'(mem_addr_a), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rmid_busy", 32'(busy_a), 32'd0);
        check("rmid_out_valid", 32'(out_valid_a), 32'd0);
        check("rmid_mem_addr", 32'(mem_addr_a), 32'd0);
        check("rmid_done", 32'(done_a), 32'd0);
        check("rmid_no_done", 32'(n_done_a - d0), 32'd0);
        push_a(8'h3C, 2'd1, 1'b1);
        issue_a(1'b0, 2'd1);
        latency_a(3);
        wait_idle_a("rmid_after");

        // Reset wins over start in the same cycle.
        reset = 1'b1; start_a = 1'b1; scan_a = 1'b1; start_addr_a = 2'd2;
        @(posedge clk); #1;
        reset = 1'b0; start_a = 1'b0;
        check("rprio_busy", 32'(busy_a), 32'd0);
        check("rprio_mem_addr", 32'(mem_addr_a), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        check("rprio_still_idle", 32'(out_valid_a), 32'd0);

        // SETTLE=4 instance: latency and a start pulse while busy.
        out_ready_b = 1'b1;
        e.data = 8'h3C; e.addr = 2'd1; e.last = 1'b1;
        qb.push_back(e);
        d0 = n_done_b;
        @(posedge clk); #1;
        start_b = 1'b1; scan_b = 1'b0; start_addr_b = 2'd1;
        @(posedge clk); #1;
        start_b = 1'b0;
        lat = 1;
        while (!out_valid_b && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 2) begin
                start_b = 1'b1; scan_b = 1'b1; start_addr_b = 2'd3;
            end else begin
                start_b = 1'b0;
            end
        end
        start_b = 1'b0;
        check("b_latency", 32'(lat), 32'd6);
        n = 0;
        while (busy_b && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        check("b_idle", 32'(busy_b), 32'd0);
        repeat (20) @(posedge clk);
        #1;
        check("b_done_count", 32'(n_done_b - d0), 32'd1);
        check("b_queue_empty", 32'(qb.size()), 32'd0);
        check("b_no_restart", 32'(busy_b), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
